// File: rtl/ram_sync_init.sv
// Parametrised data RAM: registered 1-cycle read with valid strobe and a post-reset zeroing sweep.
// Define RAM_PARITY_EN to store an even-parity bit per word and flag mismatches on read.
module ram_sync_init #(
  parameter int WIDTH          = 16,
  parameter int DEPTH          = 16384,
  parameter int ADDR_W         = 14,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic              ready,
  input  logic              parity_inj,
  output logic              parity_err
);

`ifdef RAM_PARITY_EN
  localparam int MEM_W = WIDTH + 1;
`else
  localparam int MEM_W = WIDTH;
`endif
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
  logic              ready_nxt;
  logic              in_range;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  new_word;
  logic [MEM_W-1:0]  sel_word;
  logic              rd_en;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_perr;

  logic [MEM_W-1:0]  mem [DEPTH];

  // Addresses past the last word exist only when DEPTH is not a power of two.
  assign in_range = ({1'b0, address} < DEPTH_LIM);

`ifdef RAM_PARITY_EN
  assign new_word = {(^in) ^ parity_inj, in};
`else
  logic unused_parity_inj;
  assign unused_parity_inj = parity_inj;
  assign new_word = in;
`endif

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    ready_nxt    = ready;
    wr_en        = 1'b0;
    wr_addr      = address;
    wr_word      = new_word;
    rd_en        = 1'b0;
    case (state)
      CLEAR: begin
        wr_en        = 1'b1;
        wr_addr      = clr_addr;
        wr_word      = '0;
        clr_addr_nxt = clr_addr + 1'b1;
        if (clr_addr == LAST_ADDR) begin
          state_nxt = RUN;
          ready_nxt = 1'b1;
        end
      end
      RUN: begin
        wr_en = load & in_range;
        rd_en = read;
      end
    endcase
  end

  // Write-first: a same-cycle write forwards its word straight to the read register.
  always_comb begin
    sel_word = load ? new_word : mem[address];
    rd_data  = '0;
    rd_perr  = 1'b0;
    if (in_range) begin
      rd_data = sel_word[WIDTH-1:0];
`ifdef RAM_PARITY_EN
      rd_perr = (^sel_word[WIDTH-1:0]) != sel_word[WIDTH];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_addr   <= '0;
      ready      <= !CLEAR_ON_RESET;
      out        <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_addr   <= clr_addr_nxt;
      ready      <= ready_nxt;
      out_valid  <= rd_en;
      parity_err <= rd_en & rd_perr;
      if (rd_en) out <= rd_data;
    end
  end

  // Storage has no reset so contents survive a reset when the sweep is disabled.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[wr_addr] <= wr_word;
  end

endmodule

// File: tb/tb_ram_sync_init.sv
// Scoreboard bench for ram_sync_init: default 16K instance, odd-depth instance and a no-clear instance.
module tb_ram_sync_init;

`ifdef RAM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a, load_a, read_a, pinj_a, ovalid_a, ready_a, perr_a;
  logic [15:0] in_a, out_a;
  logic [13:0] addr_a;
  logic        rst_n_b, load_b, read_b, pinj_b, ovalid_b, ready_b, perr_b;
  logic [15:0] in_b, out_b;
  logic [6:0]  addr_b;
  logic        rst_n_c, load_c, read_c, pinj_c, ovalid_c, ready_c, perr_c;
  logic [15:0] in_c, out_c;
  logic [3:0]  addr_c;

  typedef struct packed {logic [15:0] data; logic perr;} exp_t;
  exp_t exp_a[$], exp_b[$], exp_c[$];
  logic [15:0] model_a [16384];
  logic        mpar_a  [16384];
  logic [15:0] model_b [128];
  logic [15:0] model_c [16];

  int vectors     = 0;
  int miscompares = 0;

  ram_sync_init dut_a (
    .clk(clk), .rst_n(rst_n_a), .in(in_a), .load(load_a), .read(read_a), .address(addr_a),
    .out(out_a), .out_valid(ovalid_a), .ready(ready_a), .parity_inj(pinj_a), .parity_err(perr_a)
  );

  ram_sync_init #(.WIDTH(16), .DEPTH(100), .ADDR_W(7), .CLEAR_ON_RESET(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .in(in_b), .load(load_b), .read(read_b), .address(addr_b),
    .out(out_b), .out_valid(ovalid_b), .ready(ready_b), .parity_inj(pinj_b), .parity_err(perr_b)
  );

  ram_sync_init #(.WIDTH(16), .DEPTH(16), .ADDR_W(4), .CLEAR_ON_RESET(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n_c), .in(in_c), .load(load_c), .read(read_c), .address(addr_c),
    .out(out_c), .out_valid(ovalid_c), .ready(ready_c), .parity_inj(pinj_c), .parity_err(perr_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drivers push the expected read result when a request is accepted.
  task automatic drive_a(input logic ld, input logic rd, input logic [13:0] a,
                         input logic [15:0] d, input logic inj);
    exp_t e;
    load_a = ld; read_a = rd; addr_a = a; in_a = d; pinj_a = inj;
    if (rd && ready_a) begin
      e.data = ld ? d : model_a[a];
      e.perr = PAR_ON && (ld ? inj : mpar_a[a]);
      exp_a.push_back(e);
    end
    if (ld && ready_a) begin
      model_a[a] = d;
      mpar_a[a]  = inj;
    end
  endtask

  task automatic drive_b(input logic ld, input logic rd, input logic [6:0] a, input logic [15:0] d);
    exp_t e;
    load_b = ld; read_b = rd; addr_b = a; in_b = d;
    if (rd && ready_b) begin
      e.data = (a >= 7'd100) ? 16'h0000 : (ld ? d : model_b[a]);
      e.perr = 1'b0;
      exp_b.push_back(e);
    end
    if (ld && ready_b && a < 7'd100) model_b[a] = d;
  endtask

  task automatic drive_c(input logic ld, input logic rd, input logic [3:0] a, input logic [15:0] d);
    exp_t e;
    load_c = ld; read_c = rd; addr_c = a; in_c = d;
    if (rd && ready_c) begin
      e.data = ld ? d : model_c[a];
      e.perr = 1'b0;
      exp_c.push_back(e);
    end
    if (ld && ready_c) model_c[a] = d;
  endtask

  task automatic test_reset();
    int rise, strobes;
    rst_n_a = 1'b0; load_a = 1'b1; read_a = 1'b1; addr_a = 14'h0000; in_a = 16'hFFFF; pinj_a = 1'b0;
    repeat (2) tick();
    vectors += 3;
    if (ready_a !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: got %b want 0", ready_a); end
    if (ovalid_a !== 1'b0 || perr_a !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_valid: out_valid=%b parity_err=%b want 0 0", ovalid_a, perr_a);
    end
    if (out_a !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_out: got %h want 0000", out_a); end
    rst_n_a = 1'b1;
    rise = 0; strobes = 0;
    for (int n = 1; n <= 16384 + 20; n++) begin
      tick();
      if (ovalid_a !== 1'b0) strobes++;
      if (ready_a === 1'b1) begin rise = n; break; end
    end
    load_a = 1'b0; read_a = 1'b0;
    vectors += 2;
    if (rise != 16384) begin miscompares++; $display("[TB] FAIL sweep_len: ready rose after %0d cycles want 16384", rise); end
    if (strobes != 0) begin miscompares++; $display("[TB] FAIL sweep_strobe: out_valid pulsed %0d times want 0", strobes); end
    foreach (model_a[i]) begin model_a[i] = 16'h0000; mpar_a[i] = 1'b0; end
  endtask

  task automatic test_clear_values();
    exp_t e;
    logic [13:0] tab [4] = '{14'h0028, 14'h3FFF, 14'h0000, 14'h0000};
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b0, i < 3, tab[i], 16'h0000, 1'b0);
      tick();
      if (ovalid_a === 1'b1) begin
        vectors++;
        if (exp_a.size() == 0) begin miscompares++; $display("[TB] FAIL clear_rd %0d: unexpected out_valid out=%h", i, out_a); end
        else begin
          e = exp_a.pop_front();
          if (out_a !== e.data || perr_a !== e.perr) begin
            miscompares++;
            $display("[TB] FAIL clear_rd %0d: out=%h perr=%b want %h %b", i, out_a, perr_a, e.data, e.perr);
          end
        end
      end else if (exp_a.size() != 0) begin
        vectors++; miscompares++; exp_a.delete();
        $display("[TB] FAIL clear_rd %0d: out_valid=%b want 1", i, ovalid_a);
      end
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    logic        ld  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        rd  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [13:0] ad  [6] = '{14'h0028, 14'h0028, 14'h0414, 14'h0028, 14'h0000, 14'h0000};
    for (int i = 0; i < 6; i++) begin
      drive_a(ld[i], rd[i], ad[i], 16'hABCD, 1'b0);
      tick();
      if (ovalid_a === 1'b1) begin
        vectors++;
        if (exp_a.size() == 0) begin miscompares++; $display("[TB] FAIL wr_rd %0d: unexpected out_valid out=%h", i, out_a); end
        else begin
          e = exp_a.pop_front();
          if (out_a !== e.data || perr_a !== e.perr) begin
            miscompares++;
            $display("[TB] FAIL wr_rd %0d: out=%h perr=%b want %h %b", i, out_a, perr_a, e.data, e.perr);
          end
        end
      end else if (exp_a.size() != 0) begin
        vectors++; miscompares++; exp_a.delete();
        $display("[TB] FAIL wr_rd %0d: out_valid=%b want 1", i, ovalid_a);
      end
    end
    vectors++;
    if (out_a !== 16'hABCD || ovalid_a !== 1'b0) begin
      miscompares++; $display("[TB] FAIL out_hold: out=%h out_valid=%b want abcd 0", out_a, ovalid_a);
    end
  endtask

  task automatic test_collision();
    exp_t e;
    logic ld [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic rd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive_a(ld[i], rd[i], 14'h0005, 16'h1234, 1'b0);
      tick();
      if (ovalid_a === 1'b1) begin
        vectors++;
        if (exp_a.size() == 0) begin miscompares++; $display("[TB] FAIL collide %0d: unexpected out_valid out=%h", i, out_a); end
        else begin
          e = exp_a.pop_front();
          if (out_a !== e.data || perr_a !== e.perr) begin
            miscompares++;
            $display("[TB] FAIL collide %0d: out=%h perr=%b want %h %b", i, out_a, perr_a, e.data, e.perr);
          end
        end
      end else if (exp_a.size() != 0) begin
        vectors++; miscompares++; exp_a.delete();
        $display("[TB] FAIL collide %0d: out_valid=%b want 1", i, ovalid_a);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 65; i++) begin
      if (i < 64)
        drive_a(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 14'h0100 + 14'($urandom_range(0, 7)),
                16'($urandom), 1'b0);
      else
        drive_a(1'b0, 1'b0, 14'h0000, 16'h0000, 1'b0);
      tick();
      if (ovalid_a === 1'b1) begin
        vectors++;
        if (exp_a.size() == 0) begin miscompares++; $display("[TB] FAIL b2b %0d: unexpected out_valid out=%h", i, out_a); end
        else begin
          e = exp_a.pop_front();
          if (out_a !== e.data || perr_a !== e.perr) begin
            miscompares++;
            $display("[TB] FAIL b2b %0d: out=%h perr=%b want %h %b", i, out_a, perr_a, e.data, e.perr);
          end
        end
      end else if (exp_a.size() != 0) begin
        vectors++; miscompares++; exp_a.delete();
        $display("[TB] FAIL b2b %0d: out_valid=%b want 1", i, ovalid_a);
      end
    end
  endtask

  task automatic test_parity();
    exp_t e;
    logic        ld  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        rd  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [13:0] ad  [6] = '{14'h0010, 14'h0010, 14'h0010, 14'h0010, 14'h0011, 14'h0000};
    logic [15:0] dt  [6] = '{16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0003, 16'h0000};
    logic        inj [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive_a(ld[i], rd[i], ad[i], dt[i], inj[i]);
      tick();
      if (ovalid_a === 1'b1) begin
        vectors++;
        if (exp_a.size() == 0) begin miscompares++; $display("[TB] FAIL parity %0d: unexpected out_valid out=%h", i, out_a); end
        else begin
          e = exp_a.pop_front();
          if (out_a !== e.data || perr_a !== e.perr) begin
            miscompares++;
            $display("[TB] FAIL parity %0d: out=%h perr=%b want %h %b", i, out_a, perr_a, e.data, e.perr);
          end
        end
      end else if (exp_a.size() != 0) begin
        vectors++; miscompares++; exp_a.delete();
        $display("[TB] FAIL parity %0d: out_valid=%b want 1", i, ovalid_a);
      end
    end
    vectors++;
    if (perr_a !== 1'b0) begin miscompares++; $display("[TB] FAIL parity_idle: parity_err=%b want 0", perr_a); end
  endtask

  task automatic test_odd_depth();
    exp_t e;
    int rise;
    logic        ld [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        rd [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [6:0]  ad [7] = '{7'd120, 7'd120, 7'd99, 7'd99, 7'd100, 7'd56, 7'd0};
    logic [15:0] dt [7] = '{16'h00AA, 16'h0000, 16'h1357, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    rst_n_b = 1'b0; load_b = 1'b0; read_b = 1'b0; addr_b = '0; in_b = '0; pinj_b = 1'b0;
    repeat (2) tick();
    rst_n_b = 1'b1;
    repeat (50) tick();
    vectors++;
    if (ready_b !== 1'b0) begin miscompares++; $display("[TB] FAIL odd_mid: ready=%b want 0", ready_b); end
    rst_n_b = 1'b0;
    tick();
    rst_n_b = 1'b1;
    rise = 0;
    for (int n = 1; n <= 140; n++) begin
      tick();
      if (ready_b === 1'b1) begin rise = n; break; end
    end
    vectors++;
    if (rise != 100) begin miscompares++; $display("[TB] FAIL odd_sweep: ready rose after %0d cycles want 100", rise); end
    foreach (model_b[i]) model_b[i] = 16'h0000;
    for (int i = 0; i < 7; i++) begin
      drive_b(ld[i], rd[i], ad[i], dt[i]);
      tick();
      if (ovalid_b === 1'b1) begin
        vectors++;
        if (exp_b.size() == 0) begin miscompares++; $display("[TB] FAIL odd_rd %0d: unexpected out_valid out=%h", i, out_b); end
        else begin
          e = exp_b.pop_front();
          if (out_b !== e.data || perr_b !== e.perr) begin
            miscompares++;
            $display("[TB] FAIL odd_rd %0d: out=%h perr=%b want %h %b", i, out_b, perr_b, e.data, e.perr);
          end
        end
      end else if (exp_b.size() != 0) begin
        vectors++; miscompares++; exp_b.delete();
        $display("[TB] FAIL odd_rd %0d: out_valid=%b want 1", i, ovalid_b);
      end
    end
  endtask

  task automatic test_no_clear();
    exp_t e;
    logic        ld [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        rd [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0]  ad [6] = '{4'd3, 4'd15, 4'd0, 4'd3, 4'd15, 4'd0};
    logic [15:0] dt [6] = '{16'h5A5A, 16'hC3C3, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    rst_n_c = 1'b0; load_c = 1'b0; read_c = 1'b0; addr_c = '0; in_c = '0; pinj_c = 1'b0;
    repeat (2) tick();
    rst_n_c = 1'b1;
    tick();
    vectors++;
    if (ready_c !== 1'b1) begin miscompares++; $display("[TB] FAIL noclr_ready: ready=%b want 1", ready_c); end
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        rst_n_c = 1'b0;
        repeat (2) tick();
        rst_n_c = 1'b1;
      end
      drive_c(ld[i], rd[i], ad[i], dt[i]);
      tick();
      if (ovalid_c === 1'b1) begin
        vectors++;
        if (exp_c.size() == 0) begin miscompares++; $display("[TB] FAIL noclr_rd %0d: unexpected out_valid out=%h", i, out_c); end
        else begin
          e = exp_c.pop_front();
          if (out_c !== e.data || perr_c !== e.perr) begin
            miscompares++;
            $display("[TB] FAIL noclr_rd %0d: out=%h perr=%b want %h %b", i, out_c, perr_c, e.data, e.perr);
          end
        end
      end else if (exp_c.size() != 0) begin
        vectors++; miscompares++; exp_c.delete();
        $display("[TB] FAIL noclr_rd %0d: out_valid=%b want 1", i, ovalid_c);
      end
    end
  endtask

  initial begin
    rst_n_b = 1'b0; load_b = 1'b0; read_b = 1'b0; addr_b = '0; in_b = '0; pinj_b = 1'b0;
    rst_n_c = 1'b0; load_c = 1'b0; read_c = 1'b0; addr_c = '0; in_c = '0; pinj_c = 1'b0;
    test_reset();
    test_clear_values();
    test_write_read();
    test_collision();
    test_back_to_back();
    test_parity();
    test_odd_depth();
    test_no_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
